// File: rtl/riscv_pkg.sv
// Shared execute-stage types and constants used by the divide unit.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIN  = 2'b10
  } div_state_e;

endpackage

// File: rtl/add_sub.sv
// Adder/subtractor: res_o = opera_i + operb_i (T_i = 0) or opera_i - operb_i (T_i = 1).
module add_sub #(
  parameter int W = 32
) (
  input  logic [W-1:0] opera_i,
  input  logic [W-1:0] operb_i,
  input  logic         T_i,
  output logic [W-1:0] res_o
);

  always_comb begin
    res_o = opera_i + (operb_i ^ {W{T_i}}) + {{(W-1){1'b0}}, T_i};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
//
//   state | meaning
//   IDLE  | waiting for start_i; operands latched on acceptance
//   CALC  | 32 shift/trial-subtract steps
//   FIN   | sign fix-up, result_o written, valid_o pulsed
module div_unit
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] opera_i,
  input  logic [XLEN-1:0] operb_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  div_state_e        state_q, state_d;
  div_op_e           op_q, op_d;
  logic              quo_neg_q, quo_neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              valid_q, valid_d;

  logic              is_signed, a_neg, b_neg, b_zero, ovf;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic [XLEN:0]     shifted, trial_diff;
  logic              trial_ok;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  always_comb begin
    is_signed = ~op_i[0];
    a_neg     = is_signed & opera_i[XLEN-1];
    b_neg     = is_signed & operb_i[XLEN-1];
    a_abs     = a_neg ? -opera_i : opera_i;
    b_abs     = b_neg ? -operb_i : operb_i;
    b_zero    = (operb_i == '0);
    ovf       = is_signed & (opera_i == {1'b1, {(XLEN-1){1'b0}}}) & (operb_i == '1);
  end

  assign shifted = {rem_q, quo_q[XLEN-1]};

  add_sub #(.W(XLEN + 1)) u_trial (
    .opera_i (shifted),
    .operb_i ({1'b0, dvs_q}),
    .T_i     (1'b1),
    .res_o   (trial_diff)
  );

  // shifted < 2*divisor, so bit XLEN of the 33-bit difference is an exact sign.
  assign trial_ok = ~trial_diff[XLEN];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      op_q      <= DIV;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_i && !flush_i) state_d = (b_zero || ovf) ? FIN : CALC;
      CALC: begin
        if (flush_i)            state_d = IDLE;
        else if (cnt_q == '1)   state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_d      = op_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    valid_d   = 1'b0;
    quo_fix   = quo_neg_q ? -quo_q : quo_q;
    rem_fix   = rem_neg_q ? -rem_q : rem_q;
    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          op_d      = div_op_e'(op_i);
          cnt_d     = '0;
          dvs_d     = b_abs;
          // Divide-by-zero quotient stays all-ones regardless of operand signs.
          quo_neg_d = (a_neg ^ b_neg) & ~b_zero;
          rem_neg_d = a_neg;
          if (b_zero) begin
            quo_d = '1;
            rem_d = a_abs;
          end else if (ovf) begin
            quo_d = {1'b1, {(XLEN-1){1'b0}}};
            rem_d = '0;
          end else begin
            quo_d = a_abs;
            rem_d = '0;
          end
        end
      end
      CALC: begin
        if (!flush_i) begin
          rem_d = trial_ok ? trial_diff[XLEN-1:0] : shifted[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], trial_ok};
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      FIN: begin
        if (!flush_i) begin
          result_d = (op_q == REM || op_q == REMU) ? rem_fix : quo_fix;
          valid_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy_o   = (state_q != IDLE);
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: reference results and completion cycles queued at issue.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic        flush = 1'b0;
  logic        busy, valid;
  logic [31:0] res;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [31:0] last_res = '0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  div_unit dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .op_i     (op),
    .opera_i  (opa),
    .operb_i  (opb),
    .flush_i  (flush),
    .busy_o   (busy),
    .valid_o  (valid),
    .result_o (res)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 0) begin
      q = '1; r = a;
    end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = '0;
    end else if (!o[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return o[1] ? r : q;
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Drives one request across the next rising edge; called between edges.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_it, input string tag);
    exp_t e;
    start = 1'b1; op = o; opa = a; opb = b;
    if (expect_it) begin
      e.res = ref_res(o, a, b);
      e.cyc = cyc + 1 + ref_lat(o, a, b);
      e.tag = tag;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 80 && sb.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    chk({tag, "_drain"}, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.tag, "_res"}, res, mon_e.res);
        chk({mon_e.tag, "_lat"}, cyc, mon_e.cyc);
        last_res = mon_e.res;
      end
    end
  end

  typedef struct {
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    string       tag;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_res", res, 0);
    #5 rst_n = 1'b1;
    @(negedge clk); #1;

    issue(2'b01, 32'd100, 32'd7, 1, "divu_100_7");
    chk("busy_e0", busy, 1);
    repeat (32) @(posedge clk);
    #1 chk("busy_e32", busy, 1);
    @(posedge clk); #1;
    chk("busy_e33", busy, 0);
    wait_done("divu_100_7");

    vecs.push_back('{2'b11, 32'd100, 32'd7, "remu_100_7"});
    vecs.push_back('{2'b00, -32'sd7, 32'd2, "div_m7_2"});
    vecs.push_back('{2'b10, -32'sd7, 32'd2, "rem_m7_2"});
    vecs.push_back('{2'b10, 32'd7, -32'sd2, "rem_7_m2"});
    vecs.push_back('{2'b01, 32'd5, 32'd0, "divu_5_0"});
    vecs.push_back('{2'b11, 32'd5, 32'd0, "remu_5_0"});
    vecs.push_back('{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf"});
    vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf"});
    vecs.push_back('{2'b00, -32'sd5, 32'd0, "div_m5_0"});
    vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'd1, "divu_max_1"});
    vecs.push_back('{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "remu_big"});
    for (int i = 0; i < 8; i++)
      vecs.push_back('{2'($urandom_range(0, 3)), $urandom, $urandom >> $urandom_range(0, 31),
                       $sformatf("rnd%0d", i)});
    foreach (vecs[i]) begin
      issue(vecs[i].o, vecs[i].a, vecs[i].b, 1, vecs[i].tag);
      wait_done(vecs[i].tag);
    end

    // Flush mid-CALC: sampled at E11.
    issue(2'b01, 32'd1000, 32'd3, 0, "flush_calc");
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_calc_busy", busy, 0);
    repeat (40) @(negedge clk);
    chk("flush_calc_hold", res, last_res);
    issue(2'b01, 32'd9, 32'd3, 1, "divu_9_3");
    wait_done("divu_9_3");

    // Flush while in FIN.
    issue(2'b01, 32'd5, 32'd0, 0, "flush_fin");
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_fin_busy", busy, 0);
    repeat (5) @(negedge clk);
    chk("flush_fin_hold", res, last_res);

    // Flush with start in IDLE drops the request.
    flush = 1'b1;
    issue(2'b01, 32'd50, 32'd5, 0, "flush_idle");
    flush = 1'b0;
    chk("flush_idle_busy", busy, 0);
    repeat (40) @(negedge clk);

    // Back-to-back: second start sits in the valid_o cycle.
    issue(2'b00, 32'd77, 32'd7, 1, "b2b_a");
    for (int i = 0; i < 60 && !valid; i++) begin
      @(negedge clk); #1;
    end
    issue(2'b11, 32'd77, 32'd10, 1, "b2b_b");
    wait_done("b2b");

    // start pulsed mid-CALC is ignored.
    issue(2'b01, 32'd100, 32'd7, 1, "ign_start");
    repeat (10) @(negedge clk);
    issue(2'b00, 32'd12345, 32'd0, 0, "ignored");
    wait_done("ign_start");

    // Asynchronous reset mid-operation.
    issue(2'b01, 32'd1000, 32'd3, 0, "rst_mid");
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_valid", valid, 0);
    chk("rst_mid_res", res, 0);
    last_res = '0;
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst_after_res", res, 0);
    issue(2'b00, -32'sd100, 32'd9, 1, "post_rst");
    wait_done("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative RV32M divide/remainder unit in the execute stage, beside the ALU.
- Accepts DIV, DIVU, REM and REMU operations.
- Performs one restoring-division step per cycle, using the existing add_sub module as its trial subtractor.
- Exposes a start/busy/valid handshake so the hazard unit stalls the pipeline while busy_o is high.

Parameters:
- XLEN, 32, operand and result width. Only 32 is supported.
- CNT_W, 5, iteration counter width, equal to log2(XLEN).

Ports:
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  asynchronous active-low reset
- start_i  input  1  request; sampled only in IDLE
- op_i  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- opera_i  input  32  dividend
- operb_i  input  32  divisor
- flush_i  input  1  abort the current operation (branch mispredict or trap)
- busy_o  output  1  high whenever state is not IDLE
- valid_o  output  1  one-cycle pulse when result_o is updated
- result_o  output  32  quotient or remainder, registered

Behaviour:
- Reset: asynchronous on rst_ni low, regardless of any operation in flight.
  - state = IDLE, busy_o = 0, valid_o = 0, result_o = 0.
  - Counter, remainder, quotient and divisor registers are cleared.
- States: IDLE, CALC, FIN.
- IDLE, on start_i = 1 and flush_i = 0 at clock edge E0:
  - Latch op_i, the operand signs and the absolute values of the operands. Signed ops use two's-complement abs; unsigned ops pass operands through.
  - Clear the counter.
  - Next state: FIN if a special case applies, otherwise CALC.
- Special cases, which skip CALC:
  - Divisor 0: quotient = 32'hFFFFFFFF, remainder = dividend. Applies to signed and unsigned ops.
  - Signed overflow, 32'h80000000 / 32'hFFFFFFFF on DIV/REM: quotient = 32'h80000000, remainder = 0.
- CALC step, one per cycle:
  - Shift the {rem, quo} pair left by 1.
  - Trial subtraction via add_sub: opera_i = shifted rem, operb_i = divisor, T_i = 1.
  - If the trial is non-negative (unsigned compare on a 33-bit extension), rem takes the difference and the quo LSB is 1; otherwise rem is kept and the LSB is 0.
  - The counter increments each step; the 32nd step, at edge E32, moves the state to FIN.
- FIN, at the next edge:
  - Signed quotient is negated when the operand signs differ.
  - Signed remainder takes the dividend's sign.
  - result_o takes the quotient (DIV/DIVU) or the remainder (REM/REMU).
  - valid_o = 1 for exactly one cycle; state returns to IDLE.
- Latency, from the start edge to the edge that raises valid_o:
  - Normal operation: 33 cycles (valid at E33).
  - Special cases: 1 cycle (valid at E1).
- Handshake rules:
  - start_i while busy_o = 1 is ignored; the operation in flight continues undisturbed.
  - A new start_i is accepted in the same cycle valid_o is high, because the state is already IDLE.
  - result_o holds its value until the next valid_o.
- Flush:
  - flush_i in CALC or FIN: state goes to IDLE at the next edge, no valid_o is produced, result_o is unchanged.
  - flush_i together with start_i in IDLE: flush wins and the request is dropped.

Decomposition:
- Shared riscv_pkg holds:
  - div_op_e enum with DIV, DIVU, REM, REMU encodings matching op_i.
  - div_state_e enum with IDLE, CALC, FIN.
  - XLEN constant.
- Sub-module: one instance of add_sub as the trial subtractor.
- Sign fix-up and abs logic stay inline.

Test Plan:
- DIVU 100 / 7 → valid_o at E33, result_o = 14. REMU of the same operands → 2. busy_o high from E0 through E32.
- DIV -7 / 2 → 32'hFFFFFFFD (-3). REM -7 / 2 → 32'hFFFFFFFF (-1). REM 7 / -2 → 1.
- DIVU 5 / 0 → 32'hFFFFFFFF at E1. REMU 5 / 0 → 5. DIV 32'h80000000 / -1 → 32'h80000000 at E1. REM of the same operands → 0.
- Flush: start DIVU 1000 / 3, raise flush_i at E10 → busy_o low after E11, no valid_o. A fresh DIVU 9 / 3 then gives 3 at 33-cycle latency.
- Back-to-back ops: start_i held high during the valid_o cycle → second op accepted immediately. A start_i pulsed mid-CALC is ignored and the result is unchanged.
- Reset: rst_ni low asynchronously at cycle 20 of an operation → outputs 0 immediately. After release, no stale valid_o.
